// File: rtl/comparator_32bit_signed_ge_serial.sv
// Digit-serial signed comparator: ge = (a >= b), eq = (a == b), scanned MSB-first
// DIGIT bits per cycle, with valid/ready handshakes on both input and output.
module comparator_32bit_signed_ge_serial #(
    parameter int WIDTH      = 32,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ge,
    output logic             eq,
    output logic             busy
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] SIGN = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ge, r_eq;
    logic             r_seen, r_dec;
    logic [DIGIT-1:0] w_da, w_db;
    logic             w_diff, w_last, w_gt;

    assign w_da   = r_a[WIDTH-1 -: DIGIT];
    assign w_db   = r_b[WIDTH-1 -: DIGIT];
    assign w_diff = (w_da != w_db);
    assign w_gt   = (w_da > w_db);
    assign w_last = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_SCAN;
            end
            S_SCAN: begin
                busy = 1'b1;
                if ((w_diff && EARLY_EXIT != 0) || w_last) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Flipping the sign bit maps two's complement onto offset binary, so a plain
    // unsigned MSB-first digit compare gives the signed ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_ge   <= 1'b0;
            r_eq   <= 1'b0;
            r_seen <= 1'b0;
            r_dec  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a    <= a ^ SIGN;
                        r_b    <= b ^ SIGN;
                        r_cnt  <= CNT_W'(N - 1);
                        r_seen <= 1'b0;
                        r_dec  <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (w_diff && EARLY_EXIT != 0) begin
                        r_ge <= w_gt;
                        r_eq <= 1'b0;
                    end else begin
                        r_a <= r_a << DIGIT;
                        r_b <= r_b << DIGIT;
                        if (!w_last) r_cnt <= r_cnt - CNT_W'(1);
                        // Full-scan mode: the most significant differing digit decides.
                        if (w_diff && !r_seen) begin
                            r_seen <= 1'b1;
                            r_dec  <= w_gt;
                        end
                        if (w_last) begin
                            if (r_seen) begin
                                r_ge <= r_dec;
                                r_eq <= 1'b0;
                            end else if (w_diff) begin
                                r_ge <= w_gt;
                                r_eq <= 1'b0;
                            end else begin
                                r_ge <= 1'b1;
                                r_eq <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_ge <= 1'b0;
                        r_eq <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ge = r_ge;
    assign eq = r_eq;

endmodule

// File: tb/tb_comparator_32bit_signed_ge_serial.sv
// Directed and randomized checks of the serial signed >= comparator across
// DIGIT=4 (early/full scan), DIGIT=1 and DIGIT=32 instances sharing one stimulus bus.
module tb_comparator_32bit_signed_ge_serial;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a, b;
    logic [3:0]  ir, ov, ge, eq, bs;

    int checks = 0;
    int passed = 0;
    int lat_q[4];
    logic [3:0] got_ge, got_eq;
    int  dg[4] = '{4, 4, 1, 32};
    bit  ee[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    typedef struct {
        logic [31:0] a, b;
        logic        ge, eq;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    comparator_32bit_signed_ge_serial #(.WIDTH(32), .DIGIT(4), .EARLY_EXIT(1)) u_d4e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
        .out_valid(ov[0]), .out_ready(out_ready), .ge(ge[0]), .eq(eq[0]), .busy(bs[0]));
    comparator_32bit_signed_ge_serial #(.WIDTH(32), .DIGIT(4), .EARLY_EXIT(0)) u_d4f (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
        .out_valid(ov[1]), .out_ready(out_ready), .ge(ge[1]), .eq(eq[1]), .busy(bs[1]));
    comparator_32bit_signed_ge_serial #(.WIDTH(32), .DIGIT(1), .EARLY_EXIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
        .out_valid(ov[2]), .out_ready(out_ready), .ge(ge[2]), .eq(eq[2]), .busy(bs[2]));
    comparator_32bit_signed_ge_serial #(.WIDTH(32), .DIGIT(32), .EARLY_EXIT(1)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b),
        .out_valid(ov[3]), .out_ready(out_ready), .ge(ge[3]), .eq(eq[3]), .busy(bs[3]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected latency: index of the first differing offset-binary digit.
    function automatic int exp_lat(input logic [31:0] va, input logic [31:0] vb,
                                   input int d, input bit early);
        logic [31:0] xa, xb;
        int n;
        n  = 32 / d;
        xa = va ^ 32'h8000_0000;
        xb = vb ^ 32'h8000_0000;
        if (!early) return n;
        for (int k = 0; k < n; k++)
            if ((xa >> (32 - d * (k + 1))) != (xb >> (32 - d * (k + 1)))) return k + 1;
        return n;
    endfunction

    // Accept one operand pair on all instances, collect result and latency, then consume.
    task automatic run_cmp(input logic [31:0] va, input logic [31:0] vb);
        int c;
        a = va; b = vb; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        for (int i = 0; i < 4; i++) lat_q[i] = 0;
        got_ge = '0; got_eq = '0;
        c = 0;
        while ((lat_q[0] == 0 || lat_q[1] == 0 || lat_q[2] == 0 || lat_q[3] == 0) && c < 100) begin
            step();
            c++;
            for (int i = 0; i < 4; i++)
                if (ov[i] && lat_q[i] == 0) begin
                    lat_q[i] = c; got_ge[i] = ge[i]; got_eq[i] = eq[i];
                end
        end
        checks++;
        if (c >= 100) $display("FAIL timeout a=%h b=%h out_valid=%b required=1111", va, vb, ov);
        else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (ir !== 4'hF || ov !== 4'h0 || ge !== 4'h0 || eq !== 4'h0)
            $display("FAIL release ir=%b ov=%b ge=%b eq=%b required ir=1111 ov/ge/eq=0000", ir, ov, ge, eq);
        else passed++;
    endtask

    task automatic check_result(input logic [31:0] va, input logic [31:0] vb,
                                input logic xge, input logic xeq, input int xlat0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_ge[i] !== xge || got_eq[i] !== xeq)
                $display("FAIL result inst%0d a=%h b=%h ge/eq=%b%b required %b%b",
                         i, va, vb, got_ge[i], got_eq[i], xge, xeq);
            else passed++;
            checks++;
            if (lat_q[i] != ((i == 0 && xlat0 > 0) ? xlat0 : exp_lat(va, vb, dg[i], ee[i])))
                $display("FAIL latency inst%0d a=%h b=%h got=%0d required=%0d", i, va, vb,
                         lat_q[i], (i == 0 && xlat0 > 0) ? xlat0 : exp_lat(va, vb, dg[i], ee[i]));
            else passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        step(); step();
        rst = 1'b0;
        checks++;
        if (ir !== 4'hF || ov !== 4'h0 || ge !== 4'h0 || eq !== 4'h0 || bs !== 4'h0)
            $display("FAIL reset ir=%b ov=%b ge=%b eq=%b busy=%b required 1111/0000/0000/0000/0000",
                     ir, ov, ge, eq, bs);
        else passed++;
        // out_ready with nothing pending must do nothing
        out_ready = 1'b1;
        step(); step();
        out_ready = 1'b0;
        checks++;
        if (ir !== 4'hF || ov !== 4'h0 || bs !== 4'h0)
            $display("FAIL idle_out_ready ir=%b ov=%b busy=%b required 1111/0000/0000", ir, ov, bs);
        else passed++;
    endtask

    task automatic test_directed();
        vec_t vt[8];
        vt[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1};
        vt[1] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1};
        vt[2] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1};
        vt[3] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 8};
        vt[4] = '{32'h0000_0011, 32'h0000_0010, 1'b1, 1'b0, 8};
        vt[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1};
        vt[6] = '{32'hFFFF_FFFB, 32'hFFFF_FFFD, 1'b0, 1'b0, 8};
        vt[7] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1};
        for (int i = 0; i < 8; i++) begin
            run_cmp(vt[i].a, vt[i].b);
            check_result(vt[i].a, vt[i].b, vt[i].ge, vt[i].eq, vt[i].lat);
        end
    endtask

    task automatic test_backpressure();
        int c;
        a = 32'h0000_0001; b = 32'h0000_0002; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        c = 0;
        while (ov !== 4'hF && c < 100) begin step(); c++; end
        checks++;
        if (c >= 100) $display("FAIL bp_timeout out_valid=%b required=1111", ov);
        else passed++;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            step();
            checks++;
            if (ov !== 4'hF || ge !== 4'h0 || eq !== 4'h0 || ir !== 4'h0 || bs !== 4'h0)
                $display("FAIL bp_hold cyc%0d ov=%b ge=%b eq=%b ir=%b busy=%b required 1111/0000/0000/0000/0000",
                         k, ov, ge, eq, ir, bs);
            else passed++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (ir !== 4'hF || ov !== 4'h0)
            $display("FAIL bp_release ir=%b ov=%b required 1111/0000", ir, ov);
        else passed++;
        step();
        checks++;
        if (bs !== 4'h0 || ov !== 4'h0)
            $display("FAIL bp_no_second_accept busy=%b ov=%b required 0000/0000", bs, ov);
        else passed++;
    endtask

    task automatic test_reset_mid_scan();
        a = 32'hFFFF_FFFB; b = 32'hFFFF_FFFD; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        checks++;
        if (bs[0] !== 1'b1 || bs[1] !== 1'b1)
            $display("FAIL mid_scan_busy busy=%b required xx11", bs);
        else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (ov !== 4'h0 || bs !== 4'h0 || ir !== 4'hF || ge !== 4'h0 || eq !== 4'h0)
            $display("FAIL rst_mid_scan ov=%b busy=%b ir=%b ge=%b eq=%b required 0000/0000/1111/0000/0000",
                     ov, bs, ir, ge, eq);
        else passed++;
        run_cmp(32'hFFFF_FFFB, 32'hFFFF_FFFD);
        check_result(32'hFFFF_FFFB, 32'hFFFF_FFFD, 1'b0, 1'b0, 8);
    endtask

    task automatic test_random();
        logic [31:0] sp[6];
        logic [31:0] va, vb;
        sp = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0001};
        for (int n = 0; n < 250; n++) begin
            va = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
            case ($urandom_range(0, 4))
                0:       vb = va;
                1:       vb = sp[$urandom_range(0, 5)];
                2:       vb = va ^ (32'h1 << $urandom_range(0, 31));
                default: vb = $urandom;
            endcase
            run_cmp(va, vb);
            check_result(va, vb, !($signed(va) < $signed(vb)), va == vb, 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_scan();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
